// File: rtl/porta_and_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : porta_and_arbiter
// Description : Round-robin arbiter that lets N requesters share a single
//               porta_and gate. A winner's operand bits are registered onto
//               the gate inputs and held for SETTLE cycles. The gate output
//               is then sampled into result and a one-cycle done pulse is
//               returned to the owner.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   N        : number of requesters (2..8)
//   SETTLE   : cycles the operands are held in DRIVE before sampling (1..15)
// Ports
//   clk                      : clock, rising edge active
//   rst_n                    : synchronous active-low reset
//   req_i      [N-1:0]       : per-requester request level
//   a_in_i/b_in_i/c_in_i/sel_in_i [N-1:0] : per-requester operand bits
//   g_a_o/g_b_o/g_c_o/g_sel_o: registered operands to the shared gate
//   g_s_i                    : shared gate output
//   grant_o    [N-1:0]       : one-hot gate owner during DRIVE and CAPTURE
//   done_o     [N-1:0]       : one-cycle pulse when the owner's result is valid
//   result_o                 : registered gate sample, held until next capture
//   busy_o                   : high whenever the FSM is not IDLE
// ============================================================================
module porta_and_arbiter #(
    parameter int N      = 4,
    parameter int SETTLE = 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [N-1:0] req_i,
    input  logic [N-1:0] a_in_i,
    input  logic [N-1:0] b_in_i,
    input  logic [N-1:0] c_in_i,
    input  logic [N-1:0] sel_in_i,
    output logic         g_a_o,
    output logic         g_b_o,
    output logic         g_c_o,
    output logic         g_sel_o,
    input  logic         g_s_i,
    output logic [N-1:0] grant_o,
    output logic [N-1:0] done_o,
    output logic         result_o,
    output logic         busy_o
);

    localparam int IW = $clog2(N);
    localparam int CW = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DRIVE   = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [IW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [3:0]     ops_q, ops_d;        // {a, b, c, sel}
    logic           result_q, result_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   done_q, done_d;

    logic           w_win_found;
    logic [IW-1:0]  w_win_idx;

    // (base + off) mod N, with off < N so one conditional subtract suffices
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) begin
            s = s - N;
        end
        return IW'(s);
    endfunction

    function automatic logic [N-1:0] onehot(input logic [IW-1:0] i);
        logic [N-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Rotating priority scan: first set request at or above rr_ptr, wrapping
    always_comb begin
        w_win_found = 1'b0;
        w_win_idx   = '0;
        for (int off = 0; off < N; off++) begin
            if (!w_win_found && req_i[wrap_add(rr_ptr_q, off)]) begin
                w_win_found = 1'b1;
                w_win_idx   = wrap_add(rr_ptr_q, off);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        rr_ptr_d = rr_ptr_q;
        cnt_d    = cnt_q;
        ops_d    = ops_q;
        result_d = result_q;
        grant_d  = grant_q;
        done_d   = '0;
        case (state_q)
            IDLE: begin
                if (w_win_found) begin
                    idx_d   = w_win_idx;
                    ops_d   = {a_in_i[w_win_idx], b_in_i[w_win_idx],
                               c_in_i[w_win_idx], sel_in_i[w_win_idx]};
                    grant_d = onehot(w_win_idx);
                    cnt_d   = CW'(SETTLE - 1);
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                if (cnt_q == '0) begin
                    state_d = CAPTURE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            CAPTURE: begin
                // done is registered, so it appears in the cycle right after
                // CAPTURE together with the freshly sampled result
                result_d = g_s_i;
                done_d   = onehot(idx_q);
                rr_ptr_d = (idx_q == IW'(N - 1)) ? '0 : idx_q + 1'b1;
                grant_d  = '0;
                state_d  = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            rr_ptr_q <= '0;
            cnt_q    <= '0;
            ops_q    <= '0;
            result_q <= 1'b0;
            grant_q  <= '0;
            done_q   <= '0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            rr_ptr_q <= rr_ptr_d;
            cnt_q    <= cnt_d;
            ops_q    <= ops_d;
            result_q <= result_d;
            grant_q  <= grant_d;
            done_q   <= done_d;
        end
    end

    assign g_a_o    = ops_q[3];
    assign g_b_o    = ops_q[2];
    assign g_c_o    = ops_q[1];
    assign g_sel_o  = ops_q[0];
    assign grant_o  = grant_q;
    assign done_o   = done_q;
    assign result_o = result_q;
    assign busy_o   = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_porta_and_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_porta_and_arbiter
// Description : Self-checking bench. Two instances (SETTLE=1 and SETTLE=3)
//               share one stimulus stream; each drives a stub AND gate. A
//               latency-based model predicts every output every cycle, and
//               directed scenarios add hand-computed literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_porta_and_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0, a_in = '0, b_in = '0, c_in = '0, sel_in = '0;

    logic       ga0, gb0, gc0, gsel0, gs0, result0, busy0;
    logic [3:0] grant0, done0;
    logic       ga1, gb1, gc1, gsel1, gs1, result1, busy1;
    logic [3:0] grant1, done1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    assign gs0 = ga0 & gb0 & gc0 & gsel0;
    assign gs1 = ga1 & gb1 & gc1 & gsel1;

    porta_and_arbiter #(.N(4), .SETTLE(1)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .req_i(req),
        .a_in_i(a_in), .b_in_i(b_in), .c_in_i(c_in), .sel_in_i(sel_in),
        .g_a_o(ga0), .g_b_o(gb0), .g_c_o(gc0), .g_sel_o(gsel0), .g_s_i(gs0),
        .grant_o(grant0), .done_o(done0), .result_o(result0), .busy_o(busy0)
    );

    porta_and_arbiter #(.N(4), .SETTLE(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .req_i(req),
        .a_in_i(a_in), .b_in_i(b_in), .c_in_i(c_in), .sel_in_i(sel_in),
        .g_a_o(ga1), .g_b_o(gb1), .g_c_o(gc1), .g_sel_o(gsel1), .g_s_i(gs1),
        .grant_o(grant1), .done_o(done1), .result_o(result1), .busy_o(busy1)
    );

    // ---------------- model: age = cycles since acceptance, 0 = free -------
    int         md_age[2]   = '{0, 0};
    int         md_owner[2] = '{0, 0};
    int         md_rr[2]    = '{0, 0};
    logic [3:0] md_g[2]     = '{4'h0, 4'h0};   // {a,b,c,sel}
    logic       md_res[2]   = '{1'b0, 1'b0};
    logic [3:0] md_done[2]  = '{4'h0, 4'h0};

    function automatic int settle_of(input int m);
        return (m == 0) ? 1 : 3;
    endfunction

    always @(posedge clk) begin
        for (int m = 0; m < 2; m++) begin
            if (!rst_n) begin
                md_age[m] = 0; md_owner[m] = 0; md_rr[m] = 0;
                md_g[m] = 4'h0; md_res[m] = 1'b0; md_done[m] = 4'h0;
            end else begin
                md_done[m] = 4'h0;
                if (md_age[m] == settle_of(m) + 1) begin
                    md_done[m] = 4'b0001 << md_owner[m];
                    md_res[m]  = &md_g[m];
                    md_rr[m]   = (md_owner[m] + 1) % 4;
                    md_age[m]  = 0;
                end else if (md_age[m] > 0) begin
                    md_age[m] = md_age[m] + 1;
                end else if (req != 4'h0) begin
                    for (int k = 3; k >= 0; k--) begin
                        if (req[(md_rr[m] + k) % 4]) md_owner[m] = (md_rr[m] + k) % 4;
                    end
                    md_g[m] = {a_in[md_owner[m]], b_in[md_owner[m]],
                               c_in[md_owner[m]], sel_in[md_owner[m]]};
                    md_age[m] = 1;
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic cmp_inst(input int m, input logic [3:0] gr, input logic [3:0] dn,
                            input logic bz, input logic rs, input logic [3:0] gops);
        logic [3:0] eg;
        eg = (md_age[m] > 0) ? (4'b0001 << md_owner[m]) : 4'h0;
        chk($sformatf("model_grant%0d", m), 32'(gr), 32'(eg));
        chk($sformatf("model_done%0d", m), 32'(dn), 32'(md_done[m]));
        chk($sformatf("model_busy%0d", m), 32'(bz), 32'(md_age[m] > 0));
        chk($sformatf("model_result%0d", m), 32'(rs), 32'(md_res[m]));
        chk($sformatf("model_gops%0d", m), 32'(gops), 32'(md_g[m]));
    endtask

    always @(posedge clk) begin
        #1;
        cmp_inst(0, grant0, done0, busy0, result0, {ga0, gb0, gc0, gsel0});
        cmp_inst(1, grant1, done1, busy1, result1, {ga1, gb1, gc1, gsel1});
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        @(negedge clk);
        req = '0;
        repeat (n) step();
    endtask

    // leaves the caller at a negedge with rst_n just released
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '0;
        step();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_grant0", 32'(grant0), 0);
        chk("rst_busy0", 32'(busy0), 0);
        chk("rst_result0", 32'(result0), 0);
        chk("rst_gops0", 32'({ga0, gb0, gc0, gsel0}), 0);
        chk("rst_done1", 32'(done1), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // single request from requester 2, all operands high
        @(negedge clk);
        req = 4'b0100; a_in = 4'b0100; b_in = 4'b0100; c_in = 4'b0100; sel_in = 4'b0100;
        step();
        chk("single_c1_grant0", 32'(grant0), 32'h4);
        chk("single_c1_busy0", 32'(busy0), 1);
        @(negedge clk);
        req = '0;
        step();
        chk("single_c2_grant0", 32'(grant0), 32'h4);
        chk("single_c2_done0", 32'(done0), 0);
        step();
        chk("single_c3_done0", 32'(done0), 32'h4);
        chk("single_c3_result0", 32'(result0), 1);
        chk("single_c3_busy0", 32'(busy0), 0);
        chk("single_c3_grant1", 32'(grant1), 32'h4);
        step();
        chk("single_c4_done0", 32'(done0), 0);
        chk("single_c4_grant1", 32'(grant1), 32'h4);
        step();
        chk("single_c5_done1", 32'(done1), 32'h4);
        chk("single_c5_result1", 32'(result1), 1);
        idle(3);

        // round robin with all requesters held
        do_reset();
        req = 4'b1111;
        a_in = 4'($urandom); b_in = 4'($urandom); c_in = 4'($urandom); sel_in = 4'($urandom);
        for (int c = 1; c <= 13; c++) begin
            step();
            if (c % 3 == 1)
                chk($sformatf("rr_c%0d_grant0", c), 32'(grant0), 32'(4'b0001 << (((c - 1) / 3) % 4)));
            if (c % 3 == 0)
                chk($sformatf("rr_c%0d_done0", c), 32'(done0), 32'(4'b0001 << ((c / 3 - 1) % 4)));
            if (c % 3 == 2)
                chk($sformatf("rr_c%0d_done0_clear", c), 32'(done0), 0);
        end
        idle(8);

        // operand stability after acceptance (requester 0)
        do_reset();
        req = 4'b0001; a_in = 4'hF; b_in = 4'hF; c_in = 4'hF; sel_in = 4'hF;
        step();
        chk("stab_c1_gops0", 32'({ga0, gb0, gc0, gsel0}), 32'hF);
        @(negedge clk);
        req = '0; a_in = '0; b_in = '0; c_in = '0; sel_in = '0;
        step();
        chk("stab_c2_gops0", 32'({ga0, gb0, gc0, gsel0}), 32'hF);
        chk("stab_c2_grant0", 32'(grant0), 32'h1);
        step();
        chk("stab_c3_result0", 32'(result0), 1);
        chk("stab_c3_done0", 32'(done0), 32'h1);
        step();
        chk("stab_c4_grant1", 32'(grant1), 32'h1);
        chk("stab_c4_gops1", 32'({ga1, gb1, gc1, gsel1}), 32'hF);
        step();
        chk("stab_c5_done1", 32'(done1), 32'h1);
        chk("stab_c5_result1", 32'(result1), 1);
        idle(3);

        // early drop by requester 3; rotation then restarts at requester 0
        @(negedge clk);
        req = 4'b1000; a_in = 4'b1000; b_in = 4'b1000; c_in = 4'b1000; sel_in = 4'b1000;
        step();
        chk("drop_c1_grant0", 32'(grant0), 32'h8);
        @(negedge clk);
        req = '0;
        step();
        step();
        chk("drop_c3_done0", 32'(done0), 32'h8);
        chk("drop_c3_result0", 32'(result0), 1);
        step();
        step();
        chk("drop_c5_done1", 32'(done1), 32'h8);
        @(negedge clk);
        req = 4'b1111;
        step();
        chk("drop_next_grant0", 32'(grant0), 32'h1);
        chk("drop_next_grant1", 32'(grant1), 32'h1);

        // reset while both instances are in DRIVE
        @(negedge clk);
        rst_n = 1'b0;
        step();
        chk("midrst_busy0", 32'(busy0), 0);
        chk("midrst_grant0", 32'(grant0), 0);
        chk("midrst_gops0", 32'({ga0, gb0, gc0, gsel0}), 0);
        chk("midrst_result0", 32'(result0), 0);
        chk("midrst_done0", 32'(done0), 0);
        chk("midrst_busy1", 32'(busy1), 0);
        chk("midrst_result1", 32'(result1), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step();
        chk("postrst_grant0", 32'(grant0), 32'h1);
        chk("postrst_grant1", 32'(grant1), 32'h1);
        step();
        chk("postrst_c2_done0", 32'(done0), 0);
        idle(8);

        // random traffic, model-checked every cycle
        for (int i = 0; i < 80; i++) begin
            @(negedge clk);
            req    = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            a_in   = 4'($urandom | $urandom);
            b_in   = 4'($urandom | $urandom);
            c_in   = 4'($urandom | $urandom);
            sel_in = 4'($urandom | $urandom);
            rst_n  = ($urandom_range(0, 29) != 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        idle(8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
